// File: rtl/pts_pkg.sv
// Shared types and default sizing for the parallel-to-serial / serial-to-parallel pair.
package pts_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } pts_state_e;

  localparam int PTS_NUM_SAMPLES = 48;
  localparam int PTS_SAMPLE_W    = 16;

endpackage

// File: rtl/pts_counter.sv
// Sample index counter: synchronous clear, count enable, saturates at N-1 with terminal flag.
module pts_counter #(
  parameter int N  = 48,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clr,
  input  logic          en,
  output logic [IW-1:0] idx,
  output logic          tc
);

  assign tc = (idx == IW'(N - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)         idx <= '0;
    else if (clr)       idx <= '0;
    else if (en && !tc) idx <= idx + 1'b1;
  end

endmodule

// File: rtl/pts_wrapper.sv
// Parallel-to-serial frame shifter with valid/ready output handshake.
// Optional abort input enabled by defining PTS_ABORT_EN.
module pts_wrapper
  import pts_pkg::*;
#(
  parameter int NUM_SAMPLES = PTS_NUM_SAMPLES,
  parameter int SAMPLE_W    = PTS_SAMPLE_W
) (
  input  logic                                clk,
  input  logic                                n_rst,
  input  logic                                par_load,
  input  logic [NUM_SAMPLES-1:0][SAMPLE_W-1:0] data_par_in,
  output logic                                par_ready,
  output logic [SAMPLE_W-1:0]                 serial_out,
  output logic                                serial_valid,
  input  logic                                serial_ready,
`ifdef PTS_ABORT_EN
  input  logic                                abort,
`endif
  output logic                                frame_done
);

  localparam int IW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;

  pts_state_e                           state_q, state_d;
  logic [NUM_SAMPLES-1:0][SAMPLE_W-1:0] buf_q;
  logic [IW-1:0]                        idx;
  logic                                 last;
  logic                                 accept;
  logic                                 load;
  logic                                 done_d;

  assign par_ready    = (state_q == IDLE);
  assign serial_valid = (state_q == SHIFT);
  assign serial_out   = serial_valid ? buf_q[idx] : '0;
  assign accept       = serial_valid && serial_ready;
  assign load         = par_ready && par_load;

  // Held at zero throughout IDLE, so every frame starts from sample 0.
  pts_counter #(.N(NUM_SAMPLES), .IW(IW)) u_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (par_ready),
    .en    (accept),
    .idx   (idx),
    .tc    (last)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:  if (load) state_d = SHIFT;
      SHIFT: begin
`ifdef PTS_ABORT_EN
        // Abort wins over a coincident final accept.
        if (abort) state_d = IDLE;
        else
`endif
        if (accept && last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_done <= done_d;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)    buf_q <= '0;
    else if (load) buf_q <= data_par_in;
  end

endmodule

// File: tb/tb_pts_wrapper.sv
// Scoreboard bench for pts_wrapper: stimulus pushes expected samples, negedge monitor checks them.
module tb_pts_wrapper;
  import pts_pkg::*;

  localparam int NS = 48;
  localparam int SW = 16;

  logic                   tb_clk = 1'b0;
  logic                   n_rst = 1'b0;
  logic                   par_load = 1'b0;
  logic [NS-1:0][SW-1:0]  data_par_in = '0;
  logic                   par_ready;
  logic [SW-1:0]          serial_out;
  logic                   serial_valid;
  logic                   serial_ready = 1'b0;
  logic                   frame_done;
`ifdef PTS_ABORT_EN
  logic                   abort = 1'b0;
`endif

  typedef struct packed {
    logic [SW-1:0] d;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc_cyc = -100;
  int   n;
  logic fd_exp = 1'b0;

  pts_wrapper #(.NUM_SAMPLES(NS), .SAMPLE_W(SW)) dut (
    .clk          (tb_clk),
    .n_rst        (n_rst),
    .par_load     (par_load),
    .data_par_in  (data_par_in),
    .par_ready    (par_ready),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .serial_ready (serial_ready),
`ifdef PTS_ABORT_EN
    .abort        (abort),
`endif
    .frame_done   (frame_done)
  );

  always #5 tb_clk = ~tb_clk;
  always @(posedge tb_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [NS-1:0][SW-1:0] mk(input int kind);
    logic [NS-1:0][SW-1:0] f;
    for (int i = 0; i < NS; i++) begin
      case (kind)
        0:       f[i] = SW'(i);
        1:       f[i] = SW'((47 - i) % 17);
        2:       f[i] = SW'(16'hA000 + i);
        default: f[i] = SW'(16'h5500 + 3 * i);
      endcase
    end
    return f;
  endfunction

  // Monitor: compares each presented sample with the queue head, pops on accept.
  always @(negedge tb_clk) begin
    if (!n_rst) begin
      exp_q.delete();
      fd_exp = 1'b0;
    end else begin
      chk("frame_done", frame_done, fd_exp);
      fd_exp = 1'b0;
      if (!serial_valid) chk("idle_out", serial_out, 0);
      else if (exp_q.size() == 0) chk("valid_without_expect", serial_valid, 0);
      else begin
        chk("serial_out", serial_out, exp_q[0].d);
        if (serial_ready) begin
          e = exp_q.pop_front();
          if (e.last) begin
            fd_exp = 1'b1;
            last_acc_cyc = cyc;
          end
        end
      end
`ifdef PTS_ABORT_EN
      if (serial_valid && abort) begin
        fd_exp = 1'b0;
        exp_q.delete();
      end
`endif
    end
  end

  task automatic load_frame(input logic [NS-1:0][SW-1:0] f);
    chk("par_ready_idle", par_ready, 1);
    data_par_in = f;
    par_load    = 1'b1;
    for (int i = 0; i < NS; i++) exp_q.push_back('{d: f[i], last: (i == NS - 1)});
    @(posedge tb_clk); #1;
    par_load = 1'b0;
    chk("latency_valid", serial_valid, 1);
    chk("par_ready_shift", par_ready, 0);
  endtask

  // mode 0: ready held high; mode 1: ready 0,1,0,1...
  task automatic run(input int mode, input int ld_at, input int rst_at, input int abort_at,
                     output int cnt);
    cnt = 0;
    while (!frame_done && cnt < 300) begin
      serial_ready = (mode == 0) ? 1'b1 : cnt[0];
      par_load     = (cnt == ld_at);
      if (cnt == ld_at) data_par_in = mk(3);
      if (cnt == rst_at) begin
        par_load = 1'b0;
        n_rst    = 1'b0;
        #1;
        chk("rst_valid", serial_valid, 0);
        chk("rst_out", serial_out, 0);
        chk("rst_par_ready", par_ready, 1);
        repeat (2) @(posedge tb_clk);
        #1 n_rst = 1'b1;
        return;
      end
`ifdef PTS_ABORT_EN
      abort = (cnt == abort_at);
`endif
      @(posedge tb_clk); #1;
      cnt++;
`ifdef PTS_ABORT_EN
      if (abort) begin
        abort = 1'b0;
        chk("abort_valid", serial_valid, 0);
        chk("abort_par_ready", par_ready, 1);
        chk("abort_no_done", frame_done, 0);
        return;
      end
`endif
      if (!frame_done) chk("par_ready_shift", par_ready, 0);
    end
    par_load = 1'b0;
    chk("no_timeout", cnt < 300, 1);
  endtask

  initial begin
    repeat (3) @(posedge tb_clk);
    #1 n_rst = 1'b1;
    @(posedge tb_clk); #1;
    chk("reset_par_ready", par_ready, 1);
    chk("reset_valid", serial_valid, 0);
    chk("reset_out", serial_out, 0);
    chk("reset_done", frame_done, 0);

    // Ramp frame, ready always high.
    load_frame(mk(0));
    run(0, -1, -1, -1, n);
    chk("ungated_cycles", n, 48);

    // Gated ready: every sample held one extra cycle.
    load_frame(mk(1));
    run(1, -1, -1, -1, n);
    chk("gated_cycles", n, 96);

    // par_load during SHIFT must not disturb the frame.
    load_frame(mk(2));
    run(0, 10, -1, -1, n);
    chk("ignore_load_cycles", n, 48);

    // Reset mid-frame, then a fresh frame restarts at sample 0.
    load_frame(mk(0));
    run(0, -1, 20, -1, n);
    repeat (2) @(posedge tb_clk);
    #1;
    chk("post_rst_valid", serial_valid, 0);
    load_frame(mk(1));
    run(0, -1, -1, -1, n);
    chk("post_rst_cycles", n, 48);

    // Back-to-back frames.
    load_frame(mk(2));
    run(0, -1, -1, -1, n);
    chk("b2b_gap_valid", serial_valid, 0);
    load_frame(mk(0));
    chk("b2b_latency", cyc - last_acc_cyc, 2);
    run(0, -1, -1, -1, n);
    chk("b2b_cycles", n, 48);

`ifdef PTS_ABORT_EN
    load_frame(mk(3));
    run(0, -1, -1, 47, n);
    @(posedge tb_clk); #1;
    chk("abort_done_after", frame_done, 0);
    load_frame(mk(1));
    run(0, -1, -1, -1, n);
    chk("post_abort_cycles", n, 48);
`endif

    repeat (3) @(posedge tb_clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
